// File: rtl/fpu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pipe
// Brief    : Handshaked IEEE-754 single-precision unit with pipelined
//            add/sub/mul and an iterative restoring divider.
// Revision : 1.0
// ============================================================================
module fpu_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    input  logic [1:0]       opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      OUT,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_state_t;

    // Packs a result, saturating to infinity or flushing to zero on range exit
    function automatic logic [31:0] fpack(input logic s, input logic signed [9:0] e,
                                          input logic [22:0] f);
        if (e >= 10'sd255)
            fpack = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            fpack = {s, 31'd0};
        else
            fpack = {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic              sw;
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [26:0]       mx, my;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        sw  = b[30:0] > a[30:0];
        x   = sw ? b : a;
        y   = sw ? a : b;
        d   = x[30:23] - y[30:23];
        e   = $signed({2'b00, x[30:23]});
        mx  = {1'b1, x[22:0], 3'b000};
        my  = (y[30:23] == 8'd0) ? 27'd0 : ({1'b1, y[22:0], 3'b000} >> d);
        sum = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        lz  = 5'd0;
        for (int i = 0; i <= 26; i++)
            if (sum[i]) lz = 5'(26 - i);
        if (x[30:23] == 8'd0 || sum == 28'd0)
            fadd = 32'd0;
        else if (sum[27])
            fadd = fpack(x[31], e + 10'sd1, 23'(sum >> 4));
        else
            fadd = fpack(x[31], e - $signed({5'd0, lz}), 23'((sum << lz) >> 3));
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        logic              s;
        s = a[31] ^ b[31];
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            fmul = {s, 31'd0};
        else if (p[47])
            fmul = fpack(s, e + 10'sd1, 23'(p >> 24));
        else
            fmul = fpack(s, e, 23'(p >> 23));
    endfunction

    logic                    w_adv, w_acc, w_acc_pipe, w_acc_div, w_pipe_empty;
    logic [31:0]             w_b, w_res, w_sres, w_div_res;
    logic                    w_special;
    logic [1:0]              w_sflags;
    div_state_t              r_state, w_state_nxt;

    logic                    r_pv [PIPE_STAGES];
    logic [31:0]             r_pd [PIPE_STAGES];
    logic [TAG_W-1:0]        r_pt [PIPE_STAGES];

    logic [24:0]             r_rem;
    logic [23:0]             r_den;
    logic [24:0]             r_q;
    logic [4:0]              r_cnt;
    logic signed [9:0]       r_exp;
    logic                    r_sign, r_spec;
    logic [31:0]             r_sres;
    logic [1:0]              r_dflags;
    logic [TAG_W-1:0]        r_dtag;

    assign w_adv      = !out_valid || out_ready;
    assign in_ready   = w_adv && (r_state == IDLE) && (opcode != 2'b11 || w_pipe_empty);
    assign w_acc      = in_valid && in_ready;
    assign w_acc_pipe = w_acc && (opcode != 2'b11);
    assign w_acc_div  = w_acc && (opcode == 2'b11);
    assign w_b        = (opcode == 2'b01) ? {~B[31], B[30:0]} : B;
    assign w_res      = opcode[1] ? fmul(A, B) : fadd(A, w_b);

    always_comb begin
        w_pipe_empty = 1'b1;
        for (int i = 0; i < PIPE_STAGES; i++)
            if (r_pv[i]) w_pipe_empty = 1'b0;
    end

    // Divide special cases; denormal operands count as zero
    always_comb begin
        w_special = 1'b1;
        w_sres    = C_QNAN;
        w_sflags  = 2'b01;
        if (A[30:23] == 8'hFF || B[30:23] == 8'hFF || (A[30:23] == 8'd0 && B[30:23] == 8'd0)) begin
            w_sres   = C_QNAN;
        end else if (B[30:23] == 8'd0) begin
            w_sres   = {A[31] ^ B[31], 8'hFF, 23'd0};
            w_sflags = 2'b10;
        end else if (A[30:23] == 8'd0) begin
            w_sres   = {A[31] ^ B[31], 31'd0};
            w_sflags = 2'b00;
        end else begin
            w_special = 1'b0;
            w_sflags  = 2'b00;
        end
    end

    assign w_div_res = r_spec ? r_sres :
                       r_q[24] ? fpack(r_sign, r_exp, 23'(r_q >> 1)) :
                                 fpack(r_sign, r_exp - 10'sd1, 23'(r_q));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc_div) w_state_nxt = w_special ? DONE : CALC;
            CALC:    if (r_cnt == 5'd24) w_state_nxt = DONE;
            DONE:    if (w_adv) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0; r_den <= '0; r_q <= '0; r_cnt <= '0; r_exp <= '0;
            r_sign <= 1'b0; r_spec <= 1'b0; r_sres <= '0; r_dflags <= '0; r_dtag <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc_div) begin
                    r_sign   <= A[31] ^ B[31];
                    r_exp    <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
                    r_rem    <= {2'b01, A[22:0]};
                    r_den    <= {1'b1, B[22:0]};
                    r_q      <= '0;
                    r_cnt    <= '0;
                    r_spec   <= w_special;
                    r_sres   <= w_sres;
                    r_dflags <= w_sflags;
                    r_dtag   <= in_tag;
                end
                CALC: begin
                    // Remainder always stays below twice the divisor, so 25 bits suffice
                    if (r_rem >= {1'b0, r_den}) begin
                        r_q   <= {r_q[23:0], 1'b1};
                        r_rem <= (r_rem - {1'b0, r_den}) << 1;
                    end else begin
                        r_q   <= {r_q[23:0], 1'b0};
                        r_rem <= r_rem << 1;
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                default: begin end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
                r_pt[i] <= '0;
            end
        end else if (w_adv) begin
            r_pv[0] <= w_acc_pipe;
            r_pd[0] <= w_res;
            r_pt[0] <= in_tag;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    // Pipeline and divider never hold results at once, so the output mux needs no arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            OUT       <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (w_adv) begin
            if (r_pv[PIPE_STAGES-1]) begin
                out_valid <= 1'b1;
                OUT       <= r_pd[PIPE_STAGES-1];
                out_tag   <= r_pt[PIPE_STAGES-1];
                out_flags <= 2'b00;
            end else if (r_state == DONE) begin
                out_valid <= 1'b1;
                OUT       <= w_div_res;
                out_tag   <= r_dtag;
                out_flags <= r_dflags;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_pipe
// Brief    : Scoreboard bench for fpu_pipe with an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_fpu_pipe;
    localparam int PS = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   A = '0, B = '0;
    logic [1:0]    opcode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   OUT;
    logic [TW-1:0] out_tag;
    logic [1:0]    out_flags;

    fpu_pipe #(.PIPE_STAGES(PS), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        logic [1:0]    flags;
        int            acc;
        bit            cl;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] i2f(input int v);
        int   m, p;
        logic s;
        if (v == 0) return 32'd0;
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        for (int k = 0; k < 31; k++)
            if (m >= (1 << k)) p = k;
        return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    function automatic logic [31:0] pipe_model(input logic [1:0] op, input int a, input int b);
        if (op == 2'b00) return i2f(a + b);
        if (op == 2'b01) return i2f(a - b);
        if (a * b == 0)  return {((a < 0) ^ (b < 0)), 31'd0};
        return i2f(a * b);
    endfunction

    task automatic div_model(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic [1:0] f);
        int     ea, eb, e;
        logic   s;
        longint ma, mb, q;
        logic [31:0] fr;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        f  = 2'b00;
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
            r = 32'h7FC0_0000; f = 2'b01;
        end else if (eb == 0) begin
            r = {s, 8'hFF, 23'd0}; f = 2'b10;
        end else if (ea == 0) begin
            r = {s, 31'd0};
        end else begin
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            q  = (ma << 24) / mb;
            e  = ea - eb + 127;
            if (q < (64'sd1 <<< 24)) begin
                e  = e - 1;
                fr = 32'(q) & 32'h007F_FFFF;
            end else begin
                fr = 32'(q >>> 1) & 32'h007F_FFFF;
            end
            if (e >= 255)     r = {s, 8'hFF, 23'd0};
            else if (e <= 0)  r = {s, 31'd0};
            else              r = {s, 8'(e), fr[22:0]};
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0)      v[30:23] = 8'hFF;
        else if (k == 1) v[30:0]  = 31'd0;
        else if (k == 2) v[30:23] = 8'h00;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accept edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tg, input logic [31:0] er,
                         input logic [1:0] ef, input bit cl);
        int   w;
        exp_t e;
        w = 0;
        A = a; B = b; opcode = op; in_tag = tg; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
        end else begin
            e.res = er; e.tag = tg; e.flags = ef; e.acc = cyc + 1; e.cl = cl;
            e.lat = (op == 2'b11) ? 26 : PS;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int w;
        w = 0;
        while (sb.size() != 0 && w < max_cyc) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops expectations on every output transfer
    initial begin : monitor
        bit   new_res;
        exp_t e;
        new_res = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                new_res = 1'b1;
            end else begin
                if (out_valid && new_res && sb.size() != 0 && sb[0].cl)
                    check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output: got OUT=%h tag=%h expected no result", OUT, out_tag);
                    end else begin
                        e = sb.pop_front();
                        check("result", {26'd0, out_flags, out_tag, OUT}, {26'd0, e.flags, e.tag, e.res});
                    end
                end
                new_res = !out_valid || out_ready;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] o, ra, rb, rr;
        logic [TW-1:0] t;
        logic [1:0]  rf, op;
        bit          ok, rdy_low;
        int          ai, bi, k, seen;
        logic [TW-1:0] tag;
        bit          rnd_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_OUT", 64'(OUT), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 2'b00, 1'b1);
        drain(20);
        issue(2'b01, 32'h4040_0000, 32'h3F80_0000, 4'd4, 32'h4000_0000, 2'b00, 1'b1);
        issue(2'b10, 32'h4000_0000, 32'h4040_0000, 4'd5, 32'h40C0_0000, 2'b00, 1'b1);
        drain(20);

        issue(2'b11, 32'h40C0_0000, 32'h4000_0000, 4'd6, 32'h4040_0000, 2'b00, 1'b1);
        opcode = 2'b00;
        rdy_low = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (in_ready) rdy_low = 1'b0;
        end
        check("div_busy_in_ready", 64'(rdy_low), 64'd1);
        drain(40);
        issue(2'b11, 32'h3F80_0000, 32'h4040_0000, 4'd7, 32'h3EAA_AAAA, 2'b00, 1'b1);
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 4'd8, 32'h7F80_0000, 2'b10, 1'b0);
        issue(2'b11, 32'h0000_0000, 32'h0000_0000, 4'd9, 32'h7FC0_0000, 2'b01, 1'b0);
        drain(80);

        // Backpressure with three adds in flight
        out_ready = 1'b0;
        issue(2'b00, i2f(1), i2f(2), 4'd10, i2f(3), 2'b00, 1'b0);
        issue(2'b00, i2f(5), i2f(-9), 4'd11, i2f(-4), 2'b00, 1'b0);
        issue(2'b00, i2f(100), i2f(28), 4'd12, i2f(128), 2'b00, 1'b0);
        opcode = 2'b00;
        seen = 0;
        while (!out_valid && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        o = OUT; t = out_tag;
        ok = out_valid; rdy_low = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (OUT !== o || out_tag !== t || !out_valid) ok = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        check("stall_out_stable", 64'(ok), 64'd1);
        check("stall_in_ready_low", 64'(rdy_low), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(20);

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        issue(2'b10, i2f(7), i2f(3), 4'd13, i2f(21), 2'b00, 1'b0);
        seen = 0;
        while (!out_valid && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_OUT", 64'(OUT), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Reset in the middle of a divide
        issue(2'b11, 32'h40C0_0000, 32'h4000_0000, 4'd14, 32'h4040_0000, 2'b00, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("div_rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        opcode = 2'b11;
        @(negedge clk);
        check("div_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("div_rst_no_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic under random backpressure
        rnd_done = 1'b0;
        tag = '0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    k = $urandom_range(0, 9);
                    if (k < 8) begin
                        op = 2'(k % 3);
                        ai = int'($urandom_range(0, 4094)) - 2047;
                        bi = int'($urandom_range(0, 4094)) - 2047;
                        issue(op, i2f(ai), i2f(bi), tag, pipe_model(op, ai, bi), 2'b00, 1'b0);
                    end else begin
                        ra = rnd_fp();
                        rb = rnd_fp();
                        div_model(ra, rb, rr, rf);
                        issue(2'b11, ra, rb, tag, rr, rf, 1'b0);
                    end
                    tag = tag + 1'b1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
